// File: rtl/min_max_leds_if.sv
// Purpose: bundles the LED observation inputs and the decoded result outputs
//          of min_max_leds_decoder.
// Signals: osc_i     - oscillation phase from the display block
//          leds_i    - LED vector under decode (2**VALSIZE bits)
//          valid_o   - one-cycle pulse, decoded fields valid
//          mode_o    - decoded command (00 range, 01 linear, 10 off, 11 all-on)
//          min_o, max_o, val_o - decoded fields
//          err_o     - malformed frame pair, qualified by valid_o
//          busy_o    - decoder is mid-decode
// Modports: master drives the LED side, slave is the decoder.
interface min_max_leds_if #(
  parameter int unsigned VALSIZE = 4
);
  localparam int unsigned NBITS = 2 ** VALSIZE;

  logic               osc_i;
  logic [NBITS-1:0]   leds_i;
  logic               valid_o;
  logic [1:0]         mode_o;
  logic [VALSIZE-1:0] min_o;
  logic [VALSIZE-1:0] max_o;
  logic [VALSIZE-1:0] val_o;
  logic               err_o;
  logic               busy_o;

  modport master (
    output osc_i, leds_i,
    input  valid_o, mode_o, min_o, max_o, val_o, err_o, busy_o
  );

  modport slave (
    input  osc_i, leds_i,
    output valid_o, mode_o, min_o, max_o, val_o, err_o, busy_o
  );
endinterface

// File: rtl/min_max_leds_decoder.sv
// Purpose: recovers mode/min/max/value from the min/max display LED bargraph.
//          Captures the LED frame on an osc rise (hi) and on the following
//          fall (lo), bit-scans both frames, then classifies them and pulses
//          valid_o for one cycle.
// Ports:   clk_i - clock, rising edge
//          rst_i - asynchronous active-high reset
//          bus   - min_max_leds_if slave modport (osc/leds in, results out)
module min_max_leds_decoder #(
  parameter int unsigned VALSIZE = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  min_max_leds_if.slave bus
);
  localparam int unsigned NBITS = 2 ** VALSIZE;
  localparam int unsigned CW    = VALSIZE + 1;

  localparam logic [1:0] S_WAIT_RISE = 2'd0;
  localparam logic [1:0] S_WAIT_FALL = 2'd1;
  localparam logic [1:0] S_SCAN      = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               osc_q, osc_d;
  logic [NBITS-1:0]   hi_frame_q, hi_frame_d;
  logic [NBITS-1:0]   lo_frame_q, lo_frame_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Scan trackers; *_seen marks a 1 already found, *_hole a 0 after a 1.
  logic               hi_seen_q, hi_seen_d, hi_hole_q, hi_hole_d;
  logic               hi_gaps_q, hi_gaps_d;
  logic [VALSIZE-1:0] hi_first_q, hi_first_d, hi_last_q, hi_last_d;
  logic               lo_seen_q, lo_seen_d, lo_hole_q, lo_hole_d;
  logic               lo_gaps_q, lo_gaps_d;
  logic [VALSIZE-1:0] lo_first_q, lo_first_d, lo_last_q, lo_last_d;
  logic               lo_not_sub_q, lo_not_sub_d;
  // Registered outputs
  logic               valid_q, valid_d, err_q, err_d, busy_q, busy_d;
  logic [1:0]         mode_q, mode_d;
  logic [VALSIZE-1:0] min_q, min_d, max_q, max_d, val_q, val_d;

  logic               rise_c, fall_c, hb_c, lb_c;
  logic [VALSIZE-1:0] idx_c;

  assign rise_c = bus.osc_i & ~osc_q;
  assign fall_c = ~bus.osc_i & osc_q;
  assign idx_c  = cnt_q[VALSIZE-1:0];
  assign hb_c   = hi_frame_q[idx_c];
  assign lb_c   = lo_frame_q[idx_c];

  // Next-state, tracker and output computation
  always_comb begin
    state_d      = state_q;
    osc_d        = bus.osc_i;
    hi_frame_d   = hi_frame_q;
    lo_frame_d   = lo_frame_q;
    cnt_d        = cnt_q;
    hi_seen_d    = hi_seen_q;
    hi_hole_d    = hi_hole_q;
    hi_gaps_d    = hi_gaps_q;
    hi_first_d   = hi_first_q;
    hi_last_d    = hi_last_q;
    lo_seen_d    = lo_seen_q;
    lo_hole_d    = lo_hole_q;
    lo_gaps_d    = lo_gaps_q;
    lo_first_d   = lo_first_q;
    lo_last_d    = lo_last_q;
    lo_not_sub_d = lo_not_sub_q;
    valid_d      = 1'b0;
    mode_d       = mode_q;
    min_d        = min_q;
    max_d        = max_q;
    val_d        = val_q;
    err_d        = err_q;

    case (state_q)
      S_WAIT_RISE: begin
        if (rise_c) begin
          hi_frame_d = bus.leds_i;
          state_d    = S_WAIT_FALL;
        end
      end
      S_WAIT_FALL: begin
        if (fall_c) begin
          lo_frame_d   = bus.leds_i;
          cnt_d        = '0;
          hi_seen_d    = 1'b0;
          hi_hole_d    = 1'b0;
          hi_gaps_d    = 1'b0;
          hi_first_d   = '0;
          hi_last_d    = '0;
          lo_seen_d    = 1'b0;
          lo_hole_d    = 1'b0;
          lo_gaps_d    = 1'b0;
          lo_first_d   = '0;
          lo_last_d    = '0;
          lo_not_sub_d = 1'b0;
          state_d      = S_SCAN;
        end
      end
      S_SCAN: begin
        if (hb_c) begin
          if (!hi_seen_q) hi_first_d = idx_c;
          if (hi_hole_q)  hi_gaps_d  = 1'b1;
          hi_last_d = idx_c;
          hi_seen_d = 1'b1;
        end else if (hi_seen_q) begin
          hi_hole_d = 1'b1;
        end
        if (lb_c) begin
          if (!lo_seen_q) lo_first_d = idx_c;
          if (lo_hole_q)  lo_gaps_d  = 1'b1;
          lo_last_d = idx_c;
          lo_seen_d = 1'b1;
        end else if (lo_seen_q) begin
          lo_hole_d = 1'b1;
        end
        if (lb_c && !hb_c) lo_not_sub_d = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NBITS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        valid_d = 1'b1;
        mode_d  = 2'b10;
        min_d   = '0;
        max_d   = '0;
        val_d   = '0;
        err_d   = 1'b0;
        if ((&hi_frame_q) && (&lo_frame_q)) begin
          mode_d = 2'b11;
          max_d  = '1;
          val_d  = '1;
        end else if (!(|hi_frame_q) && !(|lo_frame_q)) begin
          mode_d = 2'b10;
        end else if (hi_gaps_q || lo_gaps_q || lo_not_sub_q) begin
          err_d = 1'b1;
        end else if (hi_frame_q == lo_frame_q) begin
          mode_d = (hi_first_q == '0) ? 2'b01 : 2'b00;
          min_d  = hi_first_q;
          max_d  = hi_last_q;
          val_d  = hi_last_q;
        end else if (!lo_seen_q || (lo_first_q != hi_first_q)) begin
          // Range bars must share their low edge; anything else is malformed.
          mode_d = 2'b00;
          err_d  = 1'b1;
        end else begin
          mode_d = 2'b00;
          min_d  = hi_first_q;
          max_d  = hi_last_q;
          val_d  = lo_last_q;
        end
        state_d = S_WAIT_RISE;
      end
      default: state_d = S_WAIT_RISE;
    endcase

    busy_d = (state_d != S_WAIT_RISE);
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_WAIT_RISE;
      osc_q        <= 1'b0;
      hi_frame_q   <= '0;
      lo_frame_q   <= '0;
      cnt_q        <= '0;
      hi_seen_q    <= 1'b0;
      hi_hole_q    <= 1'b0;
      hi_gaps_q    <= 1'b0;
      hi_first_q   <= '0;
      hi_last_q    <= '0;
      lo_seen_q    <= 1'b0;
      lo_hole_q    <= 1'b0;
      lo_gaps_q    <= 1'b0;
      lo_first_q   <= '0;
      lo_last_q    <= '0;
      lo_not_sub_q <= 1'b0;
      valid_q      <= 1'b0;
      mode_q       <= '0;
      min_q        <= '0;
      max_q        <= '0;
      val_q        <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      osc_q        <= osc_d;
      hi_frame_q   <= hi_frame_d;
      lo_frame_q   <= lo_frame_d;
      cnt_q        <= cnt_d;
      hi_seen_q    <= hi_seen_d;
      hi_hole_q    <= hi_hole_d;
      hi_gaps_q    <= hi_gaps_d;
      hi_first_q   <= hi_first_d;
      hi_last_q    <= hi_last_d;
      lo_seen_q    <= lo_seen_d;
      lo_hole_q    <= lo_hole_d;
      lo_gaps_q    <= lo_gaps_d;
      lo_first_q   <= lo_first_d;
      lo_last_q    <= lo_last_d;
      lo_not_sub_q <= lo_not_sub_d;
      valid_q      <= valid_d;
      mode_q       <= mode_d;
      min_q        <= min_d;
      max_q        <= max_d;
      val_q        <= val_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.mode_o  = mode_q;
  assign bus.min_o   = min_q;
  assign bus.max_o   = max_q;
  assign bus.val_o   = val_q;
  assign bus.err_o   = err_q;
  assign bus.busy_o  = busy_q;
endmodule

// File: tb/tb_min_max_leds_decoder.sv
// Purpose: directed self-checking bench for min_max_leds_decoder (VALSIZE=4).
module tb_min_max_leds_decoder;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  min_max_leds_if #(.VALSIZE(4)) bus ();

  min_max_leds_decoder #(.VALSIZE(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input logic [1:0] m, input logic [3:0] mn,
                            input logic [3:0] mx, input logic [3:0] vl, input logic e);
    chk({tag, ".mode"}, 32'(bus.mode_o), 32'(m));
    chk({tag, ".min"},  32'(bus.min_o),  32'(mn));
    chk({tag, ".max"},  32'(bus.max_o),  32'(mx));
    chk({tag, ".val"},  32'(bus.val_o),  32'(vl));
    chk({tag, ".err"},  32'(bus.err_o),  32'(e));
  endtask

  // Rise captures hi, fall captures lo; returns #1 after the fall-capture edge C.
  task automatic start_frames(input logic [15:0] hi, input logic [15:0] lo);
    @(negedge clk);
    bus.osc_i  = 1'b1;
    bus.leds_i = hi;
    @(negedge clk);
    bus.osc_i  = 1'b0;
    bus.leds_i = lo;
    @(posedge clk);
    #1;
  endtask

  task automatic run_decode(input string tag, input logic [15:0] hi, input logic [15:0] lo,
                            input logic [1:0] m, input logic [3:0] mn, input logic [3:0] mx,
                            input logic [3:0] vl, input logic e);
    int lat;
    start_frames(hi, lo);
    lat = 0;
    while (lat < 40 && bus.valid_o !== 1'b1) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd17);
    chk_fields(tag, m, mn, mx, vl, e);
    @(posedge clk);
    #1;
    chk({tag, ".valid_drop"}, 32'(bus.valid_o), 32'd0);
  endtask

  initial begin
    int pulses;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    bus.osc_i  = 1'b0;
    bus.leds_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 32'(bus.valid_o), 32'd0);
    chk("rst.busy",  32'(bus.busy_o),  32'd0);
    chk_fields("rst", 2'b00, 4'd0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_decode("range",   16'h1FF8, 16'h01F8, 2'b00, 4'd3, 4'd12, 4'd8,  1'b0);
    run_decode("linear",  16'h003F, 16'h003F, 2'b01, 4'd0, 4'd5,  4'd5,  1'b0);
    run_decode("rng_eq",  16'h00F0, 16'h00F0, 2'b00, 4'd4, 4'd7,  4'd7,  1'b0);
    run_decode("all_on",  16'hFFFF, 16'hFFFF, 2'b11, 4'd0, 4'd15, 4'd15, 1'b0);
    run_decode("off",     16'h0000, 16'h0000, 2'b10, 4'd0, 4'd0,  4'd0,  1'b0);
    run_decode("gaps",    16'h0505, 16'h0005, 2'b10, 4'd0, 4'd0,  4'd0,  1'b1);
    run_decode("not_sub", 16'h00F0, 16'h0F00, 2'b10, 4'd0, 4'd0,  4'd0,  1'b1);

    // osc toggling during the scan must neither recapture nor restart
    start_frames(16'h1FF8, 16'h01F8);
    chk("tog.busy_scan", 32'(bus.busy_o), 32'd1);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.osc_i  = ~bus.osc_i;
      bus.leds_i = 16'h0F0F;
    end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid_o === 1'b1) begin
        pulses++;
        chk_fields("tog", 2'b00, 4'd3, 4'd12, 4'd8, 1'b0);
      end
    end
    chk("tog.pulses", 32'(pulses), 32'd1);
    // osc held high since before DONE: no rise, so still idle
    chk("tog.no_restart", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    bus.osc_i = 1'b0;
    @(negedge clk);

    // Asynchronous reset while scanning bit 7
    start_frames(16'h00F0, 16'h00F0);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst.busy", 32'(bus.busy_o), 32'd0);
    chk_fields("arst", 2'b00, 4'd0, 4'd0, 4'd0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid_o === 1'b1) pulses++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid_o === 1'b1) pulses++;
    end
    chk("arst.no_valid", 32'(pulses), 32'd0);
    run_decode("post_rst", 16'h1FF8, 16'h01F8, 2'b00, 4'd3, 4'd12, 4'd8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/min_max_leds_decoder.md
Name: min_max_leds_decoder

Overview:
- Decoder for the LED bargraph produced by the min/max display block: it observes leds and the shared osc signal and recovers the command mode, min, max and value.
- Sits on the output side of the min/max display, in the monitor and self-check path, or in loopback on the board.
- Captures one LED frame in each osc phase, then bit-scans both frames sequentially and reports the decoded fields with a one-cycle valid pulse.

Parameters:
VALSIZE, 4, width of min/max/value; LED vector is 2**VALSIZE bits

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, asynchronous, active-high
osc_i  in  1  oscillation phase, synchronous to clk_i
leds_i  in  2**VALSIZE  LED vector under decode
valid_o  out  1  one-cycle pulse, decoded fields valid
mode_o  out  2  decoded command: 00 range, 01 linear, 10 off, 11 all-on
min_o  out  VALSIZE  decoded min
max_o  out  VALSIZE  decoded max
val_o  out  VALSIZE  decoded value
err_o  out  1  frame pair malformed; qualified by valid_o
busy_o  out  1  high outside WAIT_RISE

Behaviour:
- Reset (async, rst_i=1):
  - State is WAIT_RISE; osc_q=0; frames, scan counter and trackers are cleared.
  - All outputs are 0.
  - Reset asserted mid-scan aborts the scan with no valid_o pulse.
- osc_q registers osc_i every cycle.
  - Rise = osc_i & ~osc_q.
  - Fall = ~osc_i & osc_q.
- FSM:
  - WAIT_RISE: on rise, latch hi_frame <= leds_i, go to WAIT_FALL.
  - WAIT_FALL: on fall, latch lo_frame <= leds_i, clear counter, go to SCAN. Call this cycle C.
  - SCAN: examine bit i of both frames at cycle C+1+i, for i = 0 .. 2**VALSIZE-1. Go to DONE after the last bit.
  - DONE: at cycle C+1+2**VALSIZE, drive valid_o=1 for exactly one cycle, then go to WAIT_RISE.
  - Osc edges during SCAN/DONE are ignored. The next decode needs a fresh rise.
- Scan trackers:
  - hi_first / hi_last: lowest and highest set index in hi_frame.
  - lo_last: highest set index in lo_frame.
  - hi_gaps: set if a 0 appears in hi_frame between two 1s.
  - lo_gaps: same, for lo_frame.
  - lo_not_sub: set if a bit is set in lo_frame but clear in hi_frame.
- Classification in DONE, evaluated in this priority order:
  1. Both frames all ones: mode=11, min=0, max=all ones, val=all ones, err=0.
  2. Both frames zero: mode=10, min/max/val=0, err=0. This also covers range mode with value out of range.
  3. Any of hi_gaps, lo_gaps or lo_not_sub set: err=1, mode=10, fields 0.
  4. Frames equal and hi_first=0: mode=01, min=0, max=val=hi_last.
  5. Frames equal and hi_first>0: mode=00, min=hi_first, max=val=hi_last.
  6. Frames differ: mode=00, min=hi_first, max=hi_last, val=lo_last.
     - If lo_frame is zero, or its lowest set bit ≠ hi_first, then err=1 and the fields are 0.
- Output holding:
  - mode_o, min_o, max_o, val_o and err_o hold their last values until the next DONE.
  - valid_o is the only pulse.
- All index arithmetic is unsigned, VALSIZE bits. The scan counter is VALSIZE+1 bits so the terminal count does not wrap.

Test Plan:
1. VALSIZE=4, osc 0→1→0. Frames hi=16'h1FF8, lo=16'h01F8 → valid_o exactly 17 cycles after the fall-capture cycle; mode=00, min=3, max=12, val=8, err=0.
2. Both frames 16'h003F → mode=01, min=0, max=5, val=5, err=0. Both frames 16'h00F0 → mode=00, min=4, max=7, val=7.
3. Both frames 16'hFFFF → mode=11, max=15, val=15. Both frames 16'h0000 → mode=10, all fields 0, err=0.
4. hi=16'h0505, lo=16'h0005 → err=1, mode=10. hi=16'h00F0, lo=16'h0F00 → err=1.
5. Toggle osc_i every cycle during SCAN → no recapture, a single valid_o pulse. The next decode starts only on a rise after DONE.
6. Assert rst_i asynchronously at scan bit 7 → outputs 0 immediately, no valid_o pulse. A full frame pair after release decodes correctly.
